// File: rtl/sys_cmd_pkg.sv
// Shared opcodes, command-type and parser-state encodings for sys_cmd_parser.
package sys_cmd_pkg;
   localparam logic [7:0] OP_WR  = 8'hAA;
   localparam logic [7:0] OP_RD  = 8'hBB;
   localparam logic [7:0] OP_ALU = 8'hCC;
   localparam logic [7:0] OP_NOP = 8'hDD;

   typedef enum logic [1:0] {
      CMD_WR  = 2'd0,
      CMD_RD  = 2'd1,
      CMD_ALU = 2'd2,
      CMD_NOP = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN, NOP_FN
   } state_e;
endpackage

// File: rtl/frame_timer.sv
// Mid-frame inactivity counter; expired fires on the cycle the count would reach TIMEOUT_CYCLES.
// Only present when SYS_CMD_PARSER_TIMEOUT_EN is defined.
`ifdef SYS_CMD_PARSER_TIMEOUT_EN
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   assign expired = en && !clr && (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || !en || expired) cnt <= '0;
      else                              cnt <= cnt + 1'b1;
   end
endmodule
`endif

// File: rtl/sys_cmd_parser.sv
// Byte-stream command frame decoder with a registered valid/ready command output.
// Optional mid-frame inactivity timeout: define SYS_CMD_PARSER_TIMEOUT_EN.
module sys_cmd_parser
   import sys_cmd_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 4,
   parameter int FUNC_W         = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_byte,
   input  logic              i_byte_valid,
   input  logic              i_cmd_ready,
   output logic              o_cmd_valid,
   output logic [1:0]        o_cmd_type,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic [DATA_W-1:0] o_op_a,
   output logic [DATA_W-1:0] o_op_b,
   output logic [FUNC_W-1:0] o_func,
   output logic              o_err,
   output logic              o_overrun
);
   localparam logic [DATA_W-1:0] OPC_WR  = DATA_W'(OP_WR);
   localparam logic [DATA_W-1:0] OPC_RD  = DATA_W'(OP_RD);
   localparam logic [DATA_W-1:0] OPC_ALU = DATA_W'(OP_ALU);
   localparam logic [DATA_W-1:0] OPC_NOP = DATA_W'(OP_NOP);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_a, w_b;
   logic              expired;

   logic              done, err_set;
   cmd_type_e         n_type;
   logic [ADDR_W-1:0] n_addr;
   logic [DATA_W-1:0] n_data, n_a, n_b;
   logic [FUNC_W-1:0] n_func;

`ifdef SYS_CMD_PARSER_TIMEOUT_EN
   frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (i_clk),
      .rst     (i_rst),
      .clr     (i_byte_valid),
      .en      (state_q != IDLE),
      .expired (expired)
   );
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expired = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_byte_valid) begin
         case (state_q)
            IDLE: begin
               if      (i_byte == OPC_WR)  state_d = WR_ADDR;
               else if (i_byte == OPC_RD)  state_d = RD_ADDR;
               else if (i_byte == OPC_ALU) state_d = ALU_A;
               else if (i_byte == OPC_NOP) state_d = NOP_FN;
            end
            WR_ADDR: state_d = WR_DATA;
            ALU_A:   state_d = ALU_B;
            ALU_B:   state_d = ALU_FN;
            default: state_d = IDLE;
         endcase
      end
      if (expired) state_d = IDLE;
   end

   // Completion decode: builds the command that the final byte would load.
   always_comb begin
      done    = 1'b0;
      err_set = expired;
      n_type  = CMD_WR;
      n_addr  = '0;
      n_data  = '0;
      n_a     = '0;
      n_b     = '0;
      n_func  = '0;
      if (i_byte_valid) begin
         case (state_q)
            IDLE: err_set = !(i_byte == OPC_WR || i_byte == OPC_RD ||
                              i_byte == OPC_ALU || i_byte == OPC_NOP);
            WR_DATA: begin
               done = 1'b1; n_type = CMD_WR; n_addr = w_addr; n_data = i_byte;
            end
            RD_ADDR: begin
               done = 1'b1; n_type = CMD_RD; n_addr = i_byte[ADDR_W-1:0];
            end
            ALU_FN: begin
               done = 1'b1; n_type = CMD_ALU; n_a = w_a; n_b = w_b;
               n_func = i_byte[FUNC_W-1:0];
            end
            NOP_FN: begin
               done = 1'b1; n_type = CMD_NOP; n_func = i_byte[FUNC_W-1:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         w_addr <= '0;
         w_a    <= '0;
         w_b    <= '0;
      end else if (i_byte_valid) begin
         case (state_q)
            WR_ADDR: w_addr <= i_byte[ADDR_W-1:0];
            ALU_A:   w_a    <= i_byte;
            ALU_B:   w_b    <= i_byte;
            default: ;
         endcase
      end
   end

   // A completion may reuse the slot being handed off in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_cmd_valid <= 1'b0;
         o_cmd_type  <= '0;
         o_addr      <= '0;
         o_data      <= '0;
         o_op_a      <= '0;
         o_op_b      <= '0;
         o_func      <= '0;
         o_err       <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         if (done && (!o_cmd_valid || i_cmd_ready)) begin
            o_cmd_valid <= 1'b1;
            o_cmd_type  <= n_type;
            o_addr      <= n_addr;
            o_data      <= n_data;
            o_op_a      <= n_a;
            o_op_b      <= n_b;
            o_func      <= n_func;
         end else if (o_cmd_valid && i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
         end
         o_err     <= err_set;
         o_overrun <= done && o_cmd_valid && !i_cmd_ready;
      end
   end
endmodule

// File: tb/tb_sys_cmd_parser.sv
// Self-checking bench for sys_cmd_parser: table-driven frames plus a handshake scoreboard.
// Timeout sequence runs when SYS_CMD_PARSER_TIMEOUT_EN is defined.
module tb_sys_cmd_parser;
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic [7:0] i_byte = '0;
   logic       i_byte_valid = 1'b0;
   logic       i_cmd_ready = 1'b0;
   logic       o_cmd_valid;
   logic [1:0] o_cmd_type;
   logic [3:0] o_addr;
   logic [7:0] o_data, o_op_a, o_op_b;
   logic [3:0] o_func;
   logic       o_err, o_overrun;

   sys_cmd_parser #(.DATA_W(8), .ADDR_W(4), .FUNC_W(4), .TIMEOUT_CYCLES(16)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
      .i_cmd_ready(i_cmd_ready), .o_cmd_valid(o_cmd_valid), .o_cmd_type(o_cmd_type),
      .o_addr(o_addr), .o_data(o_data), .o_op_a(o_op_a), .o_op_b(o_op_b),
      .o_func(o_func), .o_err(o_err), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [1:0] t;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] func;
   } exp_t;

   typedef struct {
      int          n;
      logic [31:0] bytes;
      exp_t        e;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   int   err_cnt = 0;
   int   ovr_cnt = 0;
   exp_t sb[$];
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_e(logic [1:0] t, logic [3:0] addr, logic [7:0] data,
                                 logic [7:0] a, logic [7:0] b, logic [3:0] func);
      exp_t e;
      e.t = t; e.addr = addr; e.data = data; e.a = a; e.b = b; e.func = func;
      return e;
   endfunction

   function automatic vec_t mk(int n, logic [31:0] bytes, exp_t e);
      vec_t v;
      v.n = n; v.bytes = bytes; v.e = e;
      return v;
   endfunction

   // Inputs change 1 time unit after the rising edge; send_byte returns just after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      i_byte = b;
      i_byte_valid = 1'b1;
      @(posedge i_clk); #1;
      i_byte_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_clk); #1; end
   endtask

   // Scoreboard pop on every handshake; stability check while stalled.
   exp_t mon_e;
   logic mon_pv = 1'b0, mon_pr = 1'b0;
   exp_t mon_pf;
   always @(negedge i_clk) begin
      if (i_rst) begin
         mon_pv = 1'b0;
      end else begin
         if (mon_pv && !mon_pr)
            chk("stable_fields", 64'({o_cmd_type, o_addr, o_data, o_op_a, o_op_b, o_func}), 64'(mon_pf));
         if (o_cmd_valid && i_cmd_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_cmd", 64'(o_cmd_type), 64'hFFFF);
            end else begin
               mon_e = sb.pop_front();
               chk("cmd_type", 64'(o_cmd_type), 64'(mon_e.t));
               chk("cmd_addr", 64'(o_addr), 64'(mon_e.addr));
               chk("cmd_data", 64'(o_data), 64'(mon_e.data));
               chk("cmd_op_a", 64'(o_op_a), 64'(mon_e.a));
               chk("cmd_op_b", 64'(o_op_b), 64'(mon_e.b));
               chk("cmd_func", 64'(o_func), 64'(mon_e.func));
            end
         end
         if (o_err)     err_cnt++;
         if (o_overrun) ovr_cnt++;
         mon_pv = o_cmd_valid;
         mon_pr = i_cmd_ready;
         mon_pf = mk_e(o_cmd_type, o_addr, o_data, o_op_a, o_op_b, o_func);
      end
   end

   initial begin
      int exp_err;
      logic [7:0] b;
      vecs[0] = mk(3, 32'hAA053C00, mk_e(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
      vecs[1] = mk(2, 32'hBB020000, mk_e(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0));
      vecs[2] = mk(4, 32'hCC070301, mk_e(2'd2, 4'h0, 8'h00, 8'h07, 8'h03, 4'h1));
      vecs[3] = mk(2, 32'hDD0A0000, mk_e(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hA));
      vecs[4] = mk(3, 32'hAA1FFF00, mk_e(2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0));
      vecs[5] = mk(4, 32'hCCFF003A, mk_e(2'd2, 4'h0, 8'h00, 8'hFF, 8'h00, 4'hA));
      exp_err = 1;

      idle(3);
      chk("rst_valid", 64'(o_cmd_valid), 64'd0);
      chk("rst_fields", 64'({o_cmd_type, o_addr, o_data, o_op_a, o_op_b, o_func}), 64'd0);
      chk("rst_flags", 64'({o_err, o_overrun}), 64'd0);
      i_rst = 1'b0;
      i_cmd_ready = 1'b1;
      idle(1);

      // Table: each frame valid one cycle after its last strobe, gone the cycle after.
      for (int i = 0; i < 6; i++) begin
         sb.push_back(vecs[i].e);
         for (int k = 0; k < vecs[i].n; k++) begin
            b = vecs[i].bytes[31 - 8*k -: 8];
            send_byte(b);
            if (k < vecs[i].n - 1) chk("early_valid", 64'(o_cmd_valid), 64'd0);
         end
         chk("lat_valid", 64'(o_cmd_valid), 64'd1);
         idle(1);
         chk("valid_drop", 64'(o_cmd_valid), 64'd0);
      end

      // Unknown opcode.
      send_byte(8'h11);
      chk("unk_err", 64'(o_err), 64'd1);
      chk("unk_valid", 64'(o_cmd_valid), 64'd0);
      idle(1);
      chk("unk_err_1cyc", 64'(o_err), 64'd0);
      sb.push_back(mk_e(2'd1, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0));
      send_byte(8'hBB); send_byte(8'h04);
      chk("after_unk_valid", 64'(o_cmd_valid), 64'd1);
      idle(1);

      // Backpressure then overrun on the second frame.
      i_cmd_ready = 1'b0;
      sb.push_back(mk_e(2'd0, 4'h3, 8'h11, 8'h00, 8'h00, 4'h0));
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
      idle(3);
      chk("bp_held", 64'(o_cmd_valid), 64'd1);
      send_byte(8'hAA); send_byte(8'h04); send_byte(8'h22);
      chk("ovr_pulse", 64'(o_overrun), 64'd1);
      chk("ovr_keep_data", 64'(o_data), 64'h11);
      idle(1);
      chk("ovr_1cyc", 64'(o_overrun), 64'd0);
      i_cmd_ready = 1'b1;
      idle(1);
      chk("bp_release", 64'(o_cmd_valid), 64'd0);

      // Completion coincides with handshake of the pending frame.
      i_cmd_ready = 1'b0;
      sb.push_back(mk_e(2'd1, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0));
      send_byte(8'hBB); send_byte(8'h06);
      sb.push_back(mk_e(2'd0, 4'h7, 8'h55, 8'h00, 8'h00, 4'h0));
      send_byte(8'hAA); send_byte(8'h07);
      i_cmd_ready = 1'b1;
      send_byte(8'h55);
      chk("sim_valid", 64'(o_cmd_valid), 64'd1);
      chk("sim_data", 64'(o_data), 64'h55);
      chk("sim_no_ovr", 64'(o_overrun), 64'd0);
      idle(1);
      chk("sim_drain", 64'(o_cmd_valid), 64'd0);

`ifdef SYS_CMD_PARSER_TIMEOUT_EN
      send_byte(8'hAA); send_byte(8'h05);
      idle(15);
      chk("to_not_yet", 64'(o_err), 64'd0);
      idle(1);
      chk("to_err", 64'(o_err), 64'd1);
      idle(1);
      chk("to_err_1cyc", 64'(o_err), 64'd0);
      exp_err = 2;
      sb.push_back(mk_e(2'd1, 4'h8, 8'h00, 8'h00, 8'h00, 4'h0));
      send_byte(8'hBB); send_byte(8'h08);
      chk("to_recover", 64'(o_cmd_valid), 64'd1);
      idle(1);
`else
      // No timeout: a long mid-frame gap is harmless.
      sb.push_back(mk_e(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
      send_byte(8'hAA); send_byte(8'h05);
      idle(40);
      chk("gap_no_err", 64'(err_cnt), 64'd1);
      send_byte(8'h3C);
      chk("gap_complete", 64'(o_cmd_valid), 64'd1);
      idle(1);
`endif

      // Reset mid-frame with a pending command.
      i_cmd_ready = 1'b0;
      send_byte(8'hBB); send_byte(8'h09);
      send_byte(8'hCC); send_byte(8'h01);
      i_rst = 1'b1;
      idle(2);
      chk("mrst_valid", 64'(o_cmd_valid), 64'd0);
      chk("mrst_fields", 64'({o_cmd_type, o_addr, o_data, o_op_a, o_op_b, o_func}), 64'd0);
      chk("mrst_flags", 64'({o_err, o_overrun}), 64'd0);
      i_rst = 1'b0;
      i_cmd_ready = 1'b1;
      sb.push_back(mk_e(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2));
      send_byte(8'hDD); send_byte(8'h02);
      chk("mrst_decode", 64'(o_cmd_valid), 64'd1);
      idle(2);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("err_count", 64'(err_cnt), 64'(exp_err));
      chk("ovr_count", 64'(ovr_cnt), 64'd1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sys_cmd_parser.md
# sys_cmd_parser

Byte-stream command decoder sitting directly downstream of the bus synchronizer on the receive path. It consumes the synchronized byte bus and its one-cycle enable pulse, assembles multi-byte command frames (register write, register read, ALU with operands, ALU without operands), and presents each completed command on a registered valid/ready output towards the system controller. Bad opcodes, overruns and, optionally, stalled frames are flagged with single-cycle pulses.

## Interface
- DATA_W, 8: byte width of i_byte, o_data, o_op_a and o_op_b.
- ADDR_W, 4: register address width; taken from the low ADDR_W bits of the address byte.
- FUNC_W, 4: ALU function width; taken from the low FUNC_W bits of the function byte.
- TIMEOUT_CYCLES, 1024: inactivity limit mid-frame. Used only with the timeout feature.
- i_clk, in, 1: the single clock.
- i_rst, in, 1: reset. **Synchronous, active-high.**
- i_byte, in, DATA_W: synchronized byte. Sampled only when i_byte_valid is high.
- i_byte_valid, in, 1: one-cycle byte strobe (the synchronizer's enable pulse).
- i_cmd_ready, in, 1: consumer ready.
- o_cmd_valid, out, 1: command available.
- o_cmd_type, out, 2: command type, encoded as WR=0, RD=1, ALU=2, NOP=3.
- o_addr, out, ADDR_W: register address.
- o_data, out, DATA_W: write data.
- o_op_a, out, DATA_W: ALU operand A.
- o_op_b, out, DATA_W: ALU operand B.
- o_func, out, FUNC_W: ALU function.
- o_err, out, 1: one-cycle pulse on an unknown opcode or a timeout.
- o_overrun, out, 1: one-cycle pulse when a completed frame is dropped.

## Operation
- Frames:
  - 0xAA, addr, data → WR.
  - 0xBB, addr → RD.
  - 0xCC, A, B, func → ALU.
  - 0xDD, func → NOP.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FN, NOP_FN.
- FSM transitions:
  - The FSM advances only on cycles with i_byte_valid=1.
  - From IDLE, the opcode byte selects the first state of its frame.
  - The final byte of a frame returns the FSM to IDLE and completes the frame.
- Unknown opcode in IDLE: the byte is discarded, o_err pulses, and the FSM stays in IDLE.
- Working registers and output register are separate. The parser keeps accepting bytes while an output command is pending.
- On frame completion:
  - If o_cmd_valid=0, or a handshake (o_cmd_valid & i_cmd_ready) occurs in the same cycle: load the output register and set o_cmd_valid.
  - Otherwise: drop the new frame, pulse o_overrun, and leave the pending output untouched.
- Output fields not used by a command type are driven to 0. For example, RD drives o_data, o_op_a, o_op_b and o_func to 0.
- Output fields stay stable while o_cmd_valid=1 and i_cmd_ready=0.
- A handshake with no simultaneous completion clears o_cmd_valid on the next edge.

## Timing
- Reset values: FSM=IDLE, o_cmd_valid=0, all output fields=0, o_err=0, o_overrun=0, timeout counter=0.
- Reset mid-frame discards the partial frame and any pending command.
- Latency: when the final byte is strobed at edge N, o_cmd_valid=1 after edge N+1. There is no combinational path from i_byte to any output.
- o_err and o_overrun are registered and last exactly 1 cycle, asserted after the edge that sampled the causing byte or timeout.
- Back-to-back byte strobes on consecutive cycles are fully supported; there is no minimum gap.

## Configuration
- Macro: SYS_CMD_PARSER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on every i_byte_valid and increments each cycle the FSM is not in IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE, the partial frame is discarded, and o_err pulses once.
  - The counter does not run in IDLE.
- Without the macro: no counter logic exists, and the FSM waits indefinitely for the next byte.

## Structure
- Package sys_cmd_pkg holds:
  - the opcode constants (0xAA, 0xBB, 0xCC, 0xDD);
  - the cmd_type_e enum (WR/RD/ALU/NOP);
  - the parser state enum.
- One sub-module, frame_timer: the inactivity counter with a clear input, an enable input and an expiry pulse output, parameterised by TIMEOUT_CYCLES. It is instantiated only under SYS_CMD_PARSER_TIMEOUT_EN.

## Test plan
- Write frame: strobe 0xAA, 0x05, 0x3C with i_cmd_ready=1 → o_cmd_valid for 1 cycle, one cycle after the 0x3C strobe; type=0, addr=5, data=0x3C, other fields 0.
- Read and ALU frames: send 0xBB, 0x02 → type=1, addr=2. Then send 0xCC, 0x07, 0x03, 0x01 → type=2, op_a=7, op_b=3, func=1. Then send 0xDD, 0x0A → type=3, func=0xA.
- Unknown opcode: send 0x11 → o_err pulses once and no command is produced. A following 0xBB, 0x04 decodes normally.
- Backpressure and overrun: hold i_cmd_ready=0 and send two WR frames → the first stays stable and o_overrun pulses at the second completion. Then raise i_cmd_ready → the first command transfers and o_cmd_valid drops.
- Simultaneous handshake and completion: the final byte of frame 2 arrives in the handshake cycle of frame 1 → frame 2 is loaded, o_cmd_valid stays high, and there is no overrun.
- Timeout (macro on, TIMEOUT_CYCLES=16) and reset: send 0xAA, 0x05, then 16 idle cycles → o_err pulses and the FSM returns to IDLE. Separately, assert i_rst after 0xCC, 0x01 → all outputs read 0 and a subsequent 0xDD, 0x02 decodes correctly.
